// File: rtl/mc32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc32_pkg
// Description : Shared types and helpers for the mc32 register-file writeback
//               path: address/data widths, buffered writeback entry, and the
//               regFile inSelect packing function ({we, addr}).
// Revision    : 1.0 - initial release
// ============================================================================
package mc32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int SEL_WE_BIT = 5;
  localparam int SEL_W      = SEL_WE_BIT + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // regFile select word: write enable in the MSB, register address below it.
  function automatic logic [SEL_W-1:0] pack_sel(input logic we,
                                                input logic [REG_ADDR_W-1:0] addr);
    logic [SEL_W-1:0] sel;
    sel                         = '0;
    sel[SEL_WE_BIT]             = we;
    sel[REG_ADDR_W-1:0]         = addr;
    return sel;
  endfunction

endpackage : mc32_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular writeback buffer, 3 ordered push lanes, up to 2 pops
//               per cycle. Exposes head / head+1 entries, per-slot valid bits
//               and per-slot destination addresses.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push_valid[2:0]   - lane valids (lane 0 is oldest)
//               push_entry[2:0]   - lane payloads
//               n_pop             - entries retired this edge (0..2)
//               head_entry        - oldest entry
//               head1_entry       - second-oldest entry
//               entry_valid       - slot holds a buffered entry
//               entry_addr        - destination address per slot
//               count             - buffered entry count
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import mc32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [2:0]                            push_valid,
  input  wb_entry_t [2:0]                       push_entry,
  input  logic [1:0]                            n_pop,
  output wb_entry_t                             head_entry,
  output wb_entry_t                             head1_entry,
  output logic [DEPTH-1:0]                      entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr,
  output logic [CNT_W-1:0]                      count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      slot1, slot2;
  logic [1:0]            off1, off2, n_push;

  // Valid lanes are packed into consecutive slots: a lane's offset from tail
  // is the number of valid lanes ahead of it.
  always_comb begin
    mem_d   = mem_q;
    off1    = {1'b0, push_valid[0]};
    off2    = 2'(push_valid[0]) + 2'(push_valid[1]);
    n_push  = off2 + 2'(push_valid[2]);
    slot1   = tail_q + PTR_W'(off1);
    slot2   = tail_q + PTR_W'(off2);
    if (push_valid[0]) mem_d[tail_q] = push_entry[0];
    if (push_valid[1]) mem_d[slot1]  = push_entry[1];
    if (push_valid[2]) mem_d[slot2]  = push_entry[2];
    tail_d  = tail_q + PTR_W'(n_push);
    head_d  = head_q + PTR_W'(n_pop);
    count_d = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: slots are only observed while valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_entry  = mem_q[head_q];
  assign head1_entry = mem_q[head_q + PTR_W'(1)];
  assign count       = count_q;

  // A slot is live when its distance from head (mod DEPTH) is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [PTR_W-1:0] rel;
      assign rel            = PTR_W'(i) - head_q;
      assign entry_valid[i] = (CNT_W'(rel) < count_q);
      assign entry_addr[i]  = mem_q[i].addr;
    end
  endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched
// Description : Writeback scheduler in front of the dual-write-port regFile.
//               Buffers ALU/shifter/load writebacks in program order and drains
//               up to two per cycle, never two to the same register at once.
// Ports       : clk, rst                      - clock, sync active-high reset
//               alu_/shf_/mem_{valid,addr,data} - writeback requests
//               src_ready                     - room for 3 more entries
//               inp0/inSelect0, inp1/inSelect1 - regFile write ports
//               pending                       - one-hot OR of buffered dests
//               count                         - buffered entry count
//               err_drop                      - sticky dropped-request flag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched
  import mc32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_addr,
  input  logic [31:0]       alu_data,
  input  logic              shf_valid,
  input  logic [4:0]        shf_addr,
  input  logic [31:0]       shf_data,
  input  logic              mem_valid,
  input  logic [4:0]        mem_addr,
  input  logic [31:0]       mem_data,
  output logic              src_ready,
  output logic [31:0]       inp0,
  output logic [5:0]        inSelect0,
  output logic [31:0]       inp1,
  output logic [5:0]        inSelect1,
  output logic [31:0]       pending,
  output logic [CNT_W-1:0]  count,
  output logic              err_drop
);

  wb_entry_t [2:0]                     push_entry;
  logic [2:0]                          req_valid, push_valid;
  wb_entry_t                           head_entry, head1_entry;
  logic [DEPTH-1:0]                    entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr;
  logic [CNT_W-1:0]                    fifo_count;
  logic                                issue0, issue1;
  logic [1:0]                          n_pop;
  logic                                err_drop_q, err_drop_d;

  assign req_valid     = {mem_valid, shf_valid, alu_valid};
  assign push_entry[0] = wb_entry_t'{addr: alu_addr, data: alu_data};
  assign push_entry[1] = wb_entry_t'{addr: shf_addr, data: shf_data};
  assign push_entry[2] = wb_entry_t'{addr: mem_addr, data: mem_data};

  // Ready depends on registered count only, so there is no valid->ready path.
  assign src_ready  = (fifo_count <= CNT_W'(DEPTH - 3));
  assign push_valid = req_valid & {3{src_ready}};

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_entry  (push_entry),
    .n_pop       (n_pop),
    .head_entry  (head_entry),
    .head1_entry (head1_entry),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr),
    .count       (fifo_count)
  );

  // Port 1 only issues when it targets a different register than port 0;
  // otherwise the younger write waits a cycle so the last writer wins.
  // Reset suppresses both ports so nothing lands on the reset edge.
  always_comb begin
    issue0    = !rst && (fifo_count >= CNT_W'(1));
    issue1    = !rst && (fifo_count >= CNT_W'(2)) &&
                (head1_entry.addr != head_entry.addr);
    n_pop     = 2'(issue0) + 2'(issue1);
    inSelect0 = issue0 ? pack_sel(1'b1, head_entry.addr)  : '0;
    inp0      = issue0 ? head_entry.data                   : '0;
    inSelect1 = issue1 ? pack_sel(1'b1, head1_entry.addr) : '0;
    inp1      = issue1 ? head1_entry.data                  : '0;
  end

  // Entries being written this cycle stay visible until the write edge.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending[entry_addr[i]] = 1'b1;
    end
  end

  always_comb begin
    err_drop_d = err_drop_q | (!src_ready && (|req_valid));
  end

  always_ff @(posedge clk) begin
    if (rst) err_drop_q <= 1'b0;
    else     err_drop_q <= err_drop_d;
  end

  assign err_drop = err_drop_q;
  assign count    = fifo_count;

endmodule : regfile_wb_sched
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Directed self-checking bench for regfile_wb_sched with a
//               behavioural regFile model on the two write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, shf_valid, mem_valid;
  logic [4:0]  alu_addr, shf_addr, mem_addr;
  logic [31:0] alu_data, shf_data, mem_data;
  logic        src_ready;
  logic [31:0] inp0, inp1;
  logic [5:0]  inSelect0, inSelect1;
  logic [31:0] pending;
  logic [3:0]  count;
  logic        err_drop;

  logic [31:0] rf [32];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .shf_valid (shf_valid),
    .shf_addr  (shf_addr),
    .shf_data  (shf_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .src_ready (src_ready),
    .inp0      (inp0),
    .inSelect0 (inSelect0),
    .inp1      (inp1),
    .inSelect1 (inSelect1),
    .pending   (pending),
    .count     (count),
    .err_drop  (err_drop)
  );

  // regFile model: samples both ports on the rising edge.
  always @(posedge clk) begin
    if (inSelect0[5]) rf[inSelect0[4:0]] <= inp0;
    if (inSelect1[5]) rf[inSelect1[4:0]] <= inp1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; shf_valid = 0; mem_valid = 0;
    alu_addr = 0; shf_addr = 0; mem_addr = 0;
    alu_data = 0; shf_data = 0; mem_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    alu_valid = 1; shf_valid = 1; mem_valid = 1;
    alu_addr = 5'd1; shf_addr = 5'd2; mem_addr = 5'd3;
    alu_data = 32'h11; shf_data = 32'h22; mem_data = 32'h33;
    tick();
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL rst_pending got %h want 0", pending); end
    n_vec++; if (inSelect0 !== 6'd0 || inSelect1 !== 6'd0) begin n_err++; $display("FAIL rst_sel got %b/%b want 0/0", inSelect0, inSelect1); end
    n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", src_ready); end
    n_vec++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err_drop); end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_single();
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'hAAAA_AAAA;
    tick();
    idle_inputs();
    n_vec++; if (inSelect0 !== 6'b1_00011 || inp0 !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL single_p0 got %b/%h want 100011/aaaaaaaa", inSelect0, inp0); end
    n_vec++; if (inSelect1 !== 6'd0 || inp1 !== 32'h0) begin n_err++; $display("FAIL single_p1 got %b/%h want 0/0", inSelect1, inp1); end
    n_vec++; if (pending !== 32'h8) begin n_err++; $display("FAIL single_pending got %h want 8", pending); end
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL single_count got %0d want 0", count); end
    n_vec++; if (rf[3] !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL single_rf got %h want aaaaaaaa", rf[3]); end
    n_vec++; if (pending !== 32'h0) begin n_err++; $display("FAIL single_pending_clr got %h want 0", pending); end
  endtask

  task automatic test_triple();
    alu_valid = 1; alu_addr = 5'd5; alu_data = 32'd1;
    shf_valid = 1; shf_addr = 5'd7; shf_data = 32'd2;
    mem_valid = 1; mem_addr = 5'd9; mem_data = 32'd3;
    tick();
    idle_inputs();
    n_vec++; if (inSelect0 !== 6'b1_00101 || inp0 !== 32'd1) begin n_err++; $display("FAIL tri_p0 got %b/%h want 100101/1", inSelect0, inp0); end
    n_vec++; if (inSelect1 !== 6'b1_00111 || inp1 !== 32'd2) begin n_err++; $display("FAIL tri_p1 got %b/%h want 100111/2", inSelect1, inp1); end
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL tri_count3 got %0d want 3", count); end
    n_vec++; if (pending !== 32'h0000_02A0) begin n_err++; $display("FAIL tri_pending got %h want 000002a0", pending); end
    tick();
    n_vec++; if (inSelect0 !== 6'b1_01001 || inp0 !== 32'd3 || inSelect1 !== 6'd0) begin n_err++; $display("FAIL tri_c2 got %b/%h/%b want 101001/3/0", inSelect0, inp0, inSelect1); end
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL tri_count1 got %0d want 1", count); end
    tick();
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL tri_count0 got %0d want 0", count); end
    n_vec++; if (rf[5] !== 32'd1 || rf[7] !== 32'd2 || rf[9] !== 32'd3) begin n_err++; $display("FAIL tri_rf got %h/%h/%h want 1/2/3", rf[5], rf[7], rf[9]); end
  endtask

  task automatic test_same_addr();
    alu_valid = 1; alu_addr = 5'd4; alu_data = 32'hDEAD_BEEF;
    shf_valid = 1; shf_addr = 5'd4; shf_data = 32'hFACE_BEEF;
    tick();
    idle_inputs();
    n_vec++; if (inSelect0 !== 6'b1_00100 || inp0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL same_p0a got %b/%h want 100100/deadbeef", inSelect0, inp0); end
    n_vec++; if (inSelect1 !== 6'd0) begin n_err++; $display("FAIL same_p1 got %b want 0", inSelect1); end
    n_vec++; if (count !== 4'd2 || pending !== 32'h10) begin n_err++; $display("FAIL same_state got %0d/%h want 2/00000010", count, pending); end
    tick();
    n_vec++; if (inSelect0 !== 6'b1_00100 || inp0 !== 32'hFACE_BEEF) begin n_err++; $display("FAIL same_p0b got %b/%h want 100100/facebeef", inSelect0, inp0); end
    n_vec++; if (rf[4] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL same_rf_mid got %h want deadbeef", rf[4]); end
    tick();
    n_vec++; if (rf[4] !== 32'hFACE_BEEF || count !== 4'd0) begin n_err++; $display("FAIL same_rf_end got %h/%0d want facebeef/0", rf[4], count); end
  endtask

  // All entries target r12, so only one retires per cycle and the buffer
  // fills: counts go 3,5,7 then the 4th burst is dropped (count 6).
  task automatic test_overflow_wrap();
    logic [36:0] q[$];
    logic [3:0]  exp_cnt;
    int c;
    bit done;
    c = 0;
    done = 0;
    while (!done) begin
      if (inSelect0[5]) begin
        n_vec++;
        if (q.size() == 0 || {inSelect0[4:0], inp0} !== q[0]) begin
          n_err++; $display("FAIL ovf_p0 cyc %0d got %h/%h want %h", c, inSelect0[4:0], inp0, (q.size() != 0) ? q[0] : 37'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (inSelect1[5]) begin
        n_vec++;
        if (q.size() == 0 || {inSelect1[4:0], inp1} !== q[0]) begin
          n_err++; $display("FAIL ovf_p1 cyc %0d got %h/%h want %h", c, inSelect1[4:0], inp1, (q.size() != 0) ? q[0] : 37'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (c >= 1 && c <= 4) begin
        case (c)
          1:       exp_cnt = 4'd3;
          2:       exp_cnt = 4'd5;
          3:       exp_cnt = 4'd7;
          default: exp_cnt = 4'd6;
        endcase
        n_vec++; if (count !== exp_cnt) begin n_err++; $display("FAIL ovf_count cyc %0d got %0d want %0d", c, count, exp_cnt); end
      end
      if (c == 1) begin
        n_vec++; if (pending !== 32'h0000_1000) begin n_err++; $display("FAIL ovf_pending got %h want 00001000", pending); end
      end
      if (c <= 3) begin
        n_vec++; if (src_ready !== (c < 3)) begin n_err++; $display("FAIL ovf_ready cyc %0d got %b want %b", c, src_ready, (c < 3)); end
      end
      if (c == 3) begin
        n_vec++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL ovf_err_pre got %b want 0", err_drop); end
      end
      if (c == 4) begin
        n_vec++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL ovf_err_post got %b want 1", err_drop); end
      end
      if (c < 4) begin
        alu_valid = 1; alu_addr = 5'd12; alu_data = 32'h0C00_0000 + 32'(3 * c);
        shf_valid = 1; shf_addr = 5'd12; shf_data = 32'h0C00_0001 + 32'(3 * c);
        mem_valid = 1; mem_addr = 5'd12; mem_data = 32'h0C00_0002 + 32'(3 * c);
        if (c < 3) begin
          q.push_back({alu_addr, alu_data});
          q.push_back({shf_addr, shf_data});
          q.push_back({mem_addr, mem_data});
        end
      end else begin
        idle_inputs();
      end
      tick();
      c++;
      if (c >= 5 && count == 4'd0) done = 1;
      if (c > 40) begin
        n_vec++; n_err++; $display("FAIL ovf_timeout count %0d want 0", count);
        done = 1;
      end
    end
    idle_inputs();
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL ovf_left got %0d want 0", q.size()); end
    n_vec++; if (rf[12] !== 32'h0C00_0008) begin n_err++; $display("FAIL ovf_rf got %h want 0c000008", rf[12]); end
    n_vec++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL ovf_err_sticky got %b want 1", err_drop); end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_addr = 5'd20; alu_data = 32'h100;
    shf_valid = 1; shf_addr = 5'd20; shf_data = 32'h101;
    mem_valid = 1; mem_addr = 5'd20; mem_data = 32'h102;
    tick();
    mem_valid = 0;
    alu_data = 32'h103; shf_data = 32'h104;
    tick();
    idle_inputs();
    n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL rmid_count_pre got %0d want 4", count); end
    rst = 1;
    #1;
    n_vec++; if (inSelect0 !== 6'd0 || inSelect1 !== 6'd0) begin n_err++; $display("FAIL rmid_sel got %b/%b want 0/0", inSelect0, inSelect1); end
    n_vec++; if (rf[20] !== 32'h100) begin n_err++; $display("FAIL rmid_rf_pre got %h want 00000100", rf[20]); end
    tick();
    rst = 0;
    n_vec++; if (rf[20] !== 32'h100) begin n_err++; $display("FAIL rmid_rf_post got %h want 00000100", rf[20]); end
    n_vec++; if (count !== 4'd0 || pending !== 32'h0) begin n_err++; $display("FAIL rmid_state got %0d/%h want 0/0", count, pending); end
    n_vec++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL rmid_err got %b want 0", err_drop); end
    tick();
    n_vec++; if (rf[20] !== 32'h100 || inSelect0 !== 6'd0) begin n_err++; $display("FAIL rmid_quiet got %h/%b want 00000100/0", rf[20], inSelect0); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    idle_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_triple();
    test_same_addr();
    test_overflow_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_wb_sched
`default_nettype wire

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Writeback scheduler in front of the dual-write-port register file (regFile).
- Collects register writebacks from three sources (ALU, shifter, memory load) into an ordered buffer.
- Drains up to two entries per cycle onto regFile write ports 0/1 (inp0/inSelect0, inp1/inSelect1).
- Never issues two writes to the same register in one cycle.
- Exports a pending-write mask for the core's interlock logic.

Parameters:
DEPTH, 8, buffer entries; power of two, minimum 4.
CNT_W, $clog2(DEPTH)+1, width of count output.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
alu_valid  input  1  ALU writeback request
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU result
shf_valid  input  1  shifter writeback request
shf_addr  input  5  shifter destination register
shf_data  input  32  shifter result
mem_valid  input  1  load writeback request
mem_addr  input  5  load destination register
mem_data  input  32  load data
src_ready  output  1  buffer can accept up to 3 entries this cycle
inp0  output  32  regFile write data, port 0
inSelect0  output  6  regFile port 0 select; [5]=write enable, [4:0]=address
inp1  output  32  regFile write data, port 1
inSelect1  output  6  regFile port 1 select; same format as inSelect0
pending  output  32  bit r=1 when any buffered entry targets register r
count  output  CNT_W  number of buffered entries
err_drop  output  1  sticky: a request was dropped

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: head=tail=count=0, err_drop=0, src_ready=1, pending=0, inSelect0/1=0, inp0/1=0.
- Reset gating: while rst=1, inSelect0/1 are forced to 0 combinationally, so nothing is written at the reset edge even if the buffer is non-empty. Reset mid-operation discards all buffered entries.
- src_ready = (count <= DEPTH-3), derived from registered state only; no valid-to-ready path.
- Enqueue (posedge, src_ready=1):
  - Valid sources are written in fixed program order: ALU, then shifter, then memory, into consecutive slots starting at tail.
  - tail += n_push (0..3), modulo DEPTH.
- Drop (posedge, src_ready=0): any valid request is ignored and err_drop is set; it stays set until rst.
- Issue (combinational from registered buffer state only):
  - Port 0 gets the head entry if count>=1.
  - Port 1 gets the head+1 entry if count>=2 and its address differs from the head's.
  - If the two addresses are equal, only port 0 issues; the later entry becomes head next cycle, so last-writer order is preserved.
  - A non-issuing port drives inSelect=0 and inp=0.
- Pop: n_pop (0..2) entries retire at the same posedge on which regFile samples the writes; head += n_pop, modulo DEPTH.
- count_next = count + n_push - n_pop; simultaneous push and pop are legal in any combination.
- Latency: a request accepted at edge k is presented on a write port during cycle k..k+1 and written into regFile at edge k+1 at the earliest. It is delayed further by older entries ahead of it and by same-address serialisation.
- pending: OR over valid entries of one-hot(addr). Entries being issued this cycle are still included; the bit clears after the write edge.
- Registers 0..31 are all writable; no special case for r0.
- Pointer wrap is silent. Ordering across wrap is preserved.

Decomposition:
- Shared package mc32_pkg: REG_ADDR_W=5, DATA_W=32, SEL_WE_BIT=5, struct wb_entry_t {addr[4:0], data[31:0]}, and the inSelect packing function {we, addr}.
- Sub-module wb_fifo: circular buffer with 3 push lanes and 2 pop lanes, exposing head/head+1 entries and per-entry valid bits.
- regfile_wb_sched holds the issue/conflict logic, the pending mask, and the error flag.

Test Plan:
1. Reset: hold rst 2 cycles with all valids=1 -> count=0, pending=0, inSelect0=inSelect1=0, src_ready=1, err_drop=0.
2. Single write: alu r3=AAAA_AAAA -> next cycle inSelect0=6'b1_00011, inp0=AAAA_AAAA, inSelect1=0, pending=32'h8; after that edge count=0, and regFile r3 reads AAAA_AAAA.
3. Triple push: alu r5=1, shf r7=2, mem r9=3 in one cycle -> cycle+1: port0 r5=1, port1 r7=2, count=3; cycle+2: port0 r9=3, count=1; cycle+3: count=0.
4. Same-address ordering: alu r4=DEAD_BEEF, shf r4=FACE_BEEF same cycle -> cycle+1: only port0 writes r4=DEAD_BEEF; cycle+2: port0 writes r4=FACE_BEEF; regFile r4 reads FACE_BEEF.
5. Full/overflow/wrap (DEPTH=8): push 3 per cycle for 4 cycles -> src_ready=0 once count>5; requests in those cycles are dropped, err_drop=1, and dropped data is never written. Over more than 8 total entries, every accepted write lands in acceptance order.
6. Reset mid-operation: count=4, assert rst one cycle -> inSelect0/1=0 during that cycle, no regFile change, count=0 and pending=0 afterwards.
